// File: rtl/alu_pkg.sv
// Shared ALU issue-stage definitions: ALU opcodes, instruction encodings and decode control bundle.
package alu_pkg;

    localparam int DW_DEF = 16;
    localparam int RW_DEF = 3;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        OP_RTYPE = 4'b0000,
        OP_ADDI  = 4'b0100,
        OP_ANDI  = 4'b0101,
        OP_ORI   = 4'b0110,
        OP_SLTI  = 4'b0111,
        OP_LW    = 4'b1000,
        OP_SW    = 4'b1001,
        OP_BEQ   = 4'b1010
    } op_e;

    typedef enum logic [2:0] {
        F_ADD = 3'b000,
        F_SUB = 3'b010,
        F_AND = 3'b100,
        F_OR  = 3'b101,
        F_SLT = 3'b110
    } funct_e;

    typedef struct packed {
        logic [2:0] opcod;
        logic       use_imm;
        logic       rt_used;
        logic       wr;
        logic       load;
        logic       store;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side, forwarding and ALU-side signals of the issue stage.
interface alu_issue_if #(
    parameter int DW = 16,
    parameter int RW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic [2:0]    funct;
    logic [RW-1:0] rs_idx;
    logic [RW-1:0] rt_idx;
    logic [RW-1:0] rd_idx;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic [DW-1:0] imm;
    logic          exmem_wr;
    logic [RW-1:0] exmem_rd;
    logic [DW-1:0] exmem_val;
    logic          memwb_wr;
    logic [RW-1:0] memwb_rd;
    logic [DW-1:0] memwb_val;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] X;
    logic [DW-1:0] Y;
    logic [2:0]    opcod;
    logic          Cin;
    logic [RW-1:0] out_rd;
    logic          out_wr;
    logic          out_load;
    logic          out_store;
    logic          illegal_op;

    modport slave (
        input  in_valid, op, funct, rs_idx, rt_idx, rd_idx, rs_val, rt_val, imm,
        input  exmem_wr, exmem_rd, exmem_val, memwb_wr, memwb_rd, memwb_val, out_ready,
        output in_ready, out_valid, X, Y, opcod, Cin, out_rd, out_wr, out_load, out_store, illegal_op
    );

    modport master (
        output in_valid, op, funct, rs_idx, rt_idx, rd_idx, rs_val, rt_val, imm,
        output exmem_wr, exmem_rd, exmem_val, memwb_wr, memwb_rd, memwb_val, out_ready,
        input  in_ready, out_valid, X, Y, opcod, Cin, out_rd, out_wr, out_load, out_store, illegal_op
    );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational translation of major opcode / R-type funct into ALU control.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic [2:0] funct_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '{opcod: ALU_ADD, use_imm: 1'b0, rt_used: 1'b0, wr: 1'b0,
                   load: 1'b0, store: 1'b0, illegal: 1'b0};
        case (op_i)
            OP_RTYPE: begin
                ctrl_o.rt_used = 1'b1;
                ctrl_o.wr      = 1'b1;
                case (funct_i)
                    F_ADD:   ctrl_o.opcod = ALU_ADD;
                    F_SUB:   ctrl_o.opcod = ALU_SUB;
                    F_AND:   ctrl_o.opcod = ALU_AND;
                    F_OR:    ctrl_o.opcod = ALU_OR;
                    F_SLT:   ctrl_o.opcod = ALU_SLT;
                    default: ctrl_o.illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin ctrl_o.opcod = ALU_ADD; ctrl_o.use_imm = 1'b1; ctrl_o.wr = 1'b1; end
            OP_ANDI: begin ctrl_o.opcod = ALU_AND; ctrl_o.use_imm = 1'b1; ctrl_o.wr = 1'b1; end
            OP_ORI:  begin ctrl_o.opcod = ALU_OR;  ctrl_o.use_imm = 1'b1; ctrl_o.wr = 1'b1; end
            OP_SLTI: begin ctrl_o.opcod = ALU_SLT; ctrl_o.use_imm = 1'b1; ctrl_o.wr = 1'b1; end
            OP_LW: begin
                ctrl_o.opcod   = ALU_ADD;
                ctrl_o.use_imm = 1'b1;
                ctrl_o.wr      = 1'b1;
                ctrl_o.load    = 1'b1;
            end
            // Store address is rs+imm; rt carries the store data, so it is still a source.
            OP_SW: begin
                ctrl_o.opcod   = ALU_ADD;
                ctrl_o.use_imm = 1'b1;
                ctrl_o.rt_used = 1'b1;
                ctrl_o.store   = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.opcod   = ALU_SUB;
                ctrl_o.rt_used = 1'b1;
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: operand forwarding, load-use interlock and the registered ALU operation.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);

    ctrl_t         ctrl;
    logic          advance;
    logic          hazard;
    logic          in_ready;
    logic          accept;
    logic [DW-1:0] rs_fwd;
    logic [DW-1:0] rt_fwd;

    logic          vld_q,   vld_d;
    logic [DW-1:0] x_q,     x_d;
    logic [DW-1:0] y_q,     y_d;
    logic [2:0]    opcod_q, opcod_d;
    logic [RW-1:0] rd_q,    rd_d;
    logic          wr_q,    wr_d;
    logic          load_q,  load_d;
    logic          store_q, store_d;
    logic          ill_q,   ill_d;

    alu_ctrl_decode u_dec (
        .op_i    (bus.op),
        .funct_i (bus.funct),
        .ctrl_o  (ctrl)
    );

    // EX/MEM is the younger producer, so it takes priority over MEM/WB.
    function automatic logic [DW-1:0] fwd(
        input logic [RW-1:0] s,
        input logic [DW-1:0] regv,
        input logic          exwr,
        input logic [RW-1:0] exrd,
        input logic [DW-1:0] exval,
        input logic          mwwr,
        input logic [RW-1:0] mwrd,
        input logic [DW-1:0] mwval
    );
        if (s == '0)                 return '0;
        else if (exwr && exrd == s)  return exval;
        else if (mwwr && mwrd == s)  return mwval;
        else                         return regv;
    endfunction

    always_comb begin
        rs_fwd = fwd(bus.rs_idx, bus.rs_val, bus.exmem_wr, bus.exmem_rd, bus.exmem_val,
                     bus.memwb_wr, bus.memwb_rd, bus.memwb_val);
        rt_fwd = fwd(bus.rt_idx, bus.rt_val, bus.exmem_wr, bus.exmem_rd, bus.exmem_val,
                     bus.memwb_wr, bus.memwb_rd, bus.memwb_val);
    end

    always_comb begin
        advance  = !vld_q || bus.out_ready;
        hazard   = vld_q && load_q && (rd_q != '0) &&
                   ((rd_q == bus.rs_idx) || (ctrl.rt_used && (rd_q == bus.rt_idx)));
        in_ready = advance && !hazard && !rst;
        accept   = bus.in_valid && in_ready;

        vld_d   = vld_q;
        x_d     = x_q;
        y_d     = y_q;
        opcod_d = opcod_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        load_d  = load_q;
        store_d = store_q;
        ill_d   = accept && ctrl.illegal;

        if (accept && !ctrl.illegal) begin
            vld_d   = 1'b1;
            x_d     = rs_fwd;
            y_d     = ctrl.use_imm ? bus.imm : rt_fwd;
            opcod_d = ctrl.opcod;
            rd_d    = bus.rd_idx;
            wr_d    = ctrl.wr && (bus.rd_idx != '0);
            load_d  = ctrl.load;
            store_d = ctrl.store;
        end else if (advance) begin
            // Covers idle, load-use bubble and dropped illegal instructions.
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            opcod_q <= ALU_ADD;
            rd_q    <= '0;
            wr_q    <= 1'b0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            x_q     <= x_d;
            y_q     <= y_d;
            opcod_q <= opcod_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            load_q  <= load_d;
            store_q <= store_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = vld_q;
    assign bus.X          = x_q;
    assign bus.Y          = y_q;
    assign bus.opcod      = opcod_q;
    assign bus.Cin        = opcod_q[2];
    assign bus.out_rd     = rd_q;
    assign bus.out_wr     = wr_q;
    assign bus.out_load   = load_q;
    assign bus.out_store  = store_q;
    assign bus.illegal_op = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: reset, decode, forwarding, load-use stall, backpressure, illegal ops.
module tb_alu_issue_stage;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    alu_issue_if #(.DW(16), .RW(3)) bus ();

    alu_issue_stage #(.DW(16), .RW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] op, input logic [2:0] funct,
                         input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                         input logic [15:0] rsv, input logic [15:0] rtv, input logic [15:0] imm);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.funct    = funct;
        bus.rs_idx   = rs;
        bus.rt_idx   = rt;
        bus.rd_idx   = rd;
        bus.rs_val   = rsv;
        bus.rt_val   = rtv;
        bus.imm      = imm;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.op = '0; bus.funct = '0;
        bus.rs_idx = '0; bus.rt_idx = '0; bus.rd_idx = '0;
        bus.rs_val = '0; bus.rt_val = '0; bus.imm = '0;
        bus.exmem_wr = 1'b0; bus.exmem_rd = '0; bus.exmem_val = '0;
        bus.memwb_wr = 1'b0; bus.memwb_rd = '0; bus.memwb_val = '0;
        bus.out_ready = 1'b1;

        // Reset held two cycles
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        tick();
        tick();
        check("rst_valid", bus.out_valid, 0);
        check("rst_X", bus.X, 0);
        check("rst_Y", bus.Y, 0);
        check("rst_opcod", bus.opcod, 3'b010);
        check("rst_Cin", bus.Cin, 0);
        check("rst_rd", bus.out_rd, 0);
        check("rst_flags", {bus.out_wr, bus.out_load, bus.out_store, bus.illegal_op}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);

        // R-type SUB
        instr(4'b0000, 3'b010, 3'd1, 3'd2, 3'd3, 16'h0005, 16'h0003, 16'h0000);
        tick();
        check("sub_valid", bus.out_valid, 1);
        check("sub_X", bus.X, 16'h0005);
        check("sub_Y", bus.Y, 16'h0003);
        check("sub_opcod", bus.opcod, 3'b110);
        check("sub_Cin", bus.Cin, 1);
        check("sub_rd_wr", {bus.out_rd, bus.out_wr}, {3'd3, 1'b1});

        // Forwarding priority and r0
        instr(4'b0000, 3'b000, 3'd3, 3'd0, 3'd5, 16'h1111, 16'h7777, 16'h0000);
        bus.exmem_wr = 1'b1; bus.exmem_rd = 3'd3; bus.exmem_val = 16'h1234;
        bus.memwb_wr = 1'b1; bus.memwb_rd = 3'd3; bus.memwb_val = 16'hBEEF;
        tick();
        check("fwd_exmem_X", bus.X, 16'h1234);
        check("fwd_r0_Y", bus.Y, 16'h0000);
        check("fwd_add_opcod", {bus.opcod, bus.Cin}, {3'b010, 1'b0});
        bus.exmem_wr = 1'b0;
        tick();
        check("fwd_memwb_X", bus.X, 16'hBEEF);
        instr(4'b0000, 3'b000, 3'd0, 3'd0, 3'd0, 16'h9999, 16'h8888, 16'h0000);
        bus.exmem_wr = 1'b1; bus.exmem_rd = 3'd0; bus.exmem_val = 16'h5555;
        bus.memwb_wr = 1'b0;
        tick();
        check("fwd_rs0_X", bus.X, 16'h0000);
        check("rd0_no_wr", {bus.out_valid, bus.out_wr}, {1'b1, 1'b0});
        bus.exmem_wr = 1'b0;

        // Load-use stall: LW r4 then ADD r5 = r4 + r1
        instr(4'b1000, 3'b000, 3'd1, 3'd0, 3'd4, 16'h0100, 16'h0000, 16'h0004);
        tick();
        check("lw_ctrl", {bus.out_valid, bus.out_load, bus.out_wr, bus.out_store}, 4'b1110);
        check("lw_XY", {bus.X, bus.Y}, {16'h0100, 16'h0004});
        instr(4'b0000, 3'b000, 3'd4, 3'd1, 3'd5, 16'hAAAA, 16'h0001, 16'h0000);
        @(negedge clk);
        check("lu_in_ready_low", bus.in_ready, 0);
        tick();
        check("lu_bubble", bus.out_valid, 0);
        @(negedge clk);
        check("lu_in_ready_back", bus.in_ready, 1);
        bus.memwb_wr = 1'b1; bus.memwb_rd = 3'd4; bus.memwb_val = 16'h0042;
        tick();
        check("lu_add_issue", {bus.out_valid, bus.out_load}, 2'b10);
        check("lu_add_XY", {bus.X, bus.Y}, {16'h0042, 16'h0001});
        bus.memwb_wr = 1'b0;

        // Load-use via rt of SW
        instr(4'b1000, 3'b000, 3'd1, 3'd0, 3'd4, 16'h0100, 16'h0000, 16'h0008);
        tick();
        instr(4'b1001, 3'b000, 3'd2, 3'd4, 3'd0, 16'h0200, 16'h3333, 16'h0010);
        @(negedge clk);
        check("sw_in_ready_low", bus.in_ready, 0);
        tick();
        check("sw_bubble", bus.out_valid, 0);
        tick();
        check("sw_ctrl", {bus.out_valid, bus.out_store, bus.out_wr, bus.out_load}, 4'b1100);
        check("sw_XY", {bus.X, bus.Y}, {16'h0200, 16'h0010});

        // rt not a source for ADDI: no stall
        instr(4'b1000, 3'b000, 3'd1, 3'd0, 3'd4, 16'h0100, 16'h0000, 16'h0008);
        tick();
        instr(4'b0100, 3'b000, 3'd1, 3'd4, 3'd6, 16'h0020, 16'h4444, 16'h0005);
        @(negedge clk);
        check("addi_no_stall", bus.in_ready, 1);
        tick();
        check("addi_XY", {bus.X, bus.Y}, {16'h0020, 16'h0005});
        check("addi_ctrl", {bus.out_valid, bus.out_wr, bus.opcod}, {1'b1, 1'b1, 3'b010});

        // Backpressure for three cycles with an OR waiting
        bus.out_ready = 1'b0;
        instr(4'b0000, 3'b101, 3'd2, 3'd3, 3'd7, 16'h00F0, 16'h000F, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, 0);
            tick();
            check("bp_hold", {bus.out_valid, bus.X, bus.Y, bus.opcod}, {1'b1, 16'h0020, 16'h0005, 3'b010});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", bus.in_ready, 1);
        tick();
        check("bp_or_issue", {bus.X, bus.Y, bus.opcod, bus.out_rd}, {16'h00F0, 16'h000F, 3'b001, 3'd7});
        bus.in_valid = 1'b0;
        tick();
        check("idle_valid", bus.out_valid, 0);

        // Illegal opcodes
        instr(4'b1111, 3'b000, 3'd1, 3'd2, 3'd3, 16'h0001, 16'h0002, 16'h0000);
        @(negedge clk);
        check("ill_in_ready", bus.in_ready, 1);
        tick();
        check("ill_pulse", {bus.illegal_op, bus.out_valid}, 2'b10);
        bus.in_valid = 1'b0;
        tick();
        check("ill_pulse_end", bus.illegal_op, 0);
        instr(4'b0000, 3'b111, 3'd1, 3'd2, 3'd3, 16'h0001, 16'h0002, 16'h0000);
        tick();
        check("ill_funct", {bus.illegal_op, bus.out_valid}, 2'b10);

        // ANDI and SLT
        instr(4'b0101, 3'b000, 3'd1, 3'd0, 3'd2, 16'h0F0F, 16'h0000, 16'hFF00);
        tick();
        check("andi_XY", {bus.X, bus.Y}, {16'h0F0F, 16'hFF00});
        check("andi_opcod", {bus.opcod, bus.Cin, bus.illegal_op}, {3'b000, 1'b0, 1'b0});
        instr(4'b0000, 3'b110, 3'd1, 3'd2, 3'd3, 16'h0005, 16'h0003, 16'h0000);
        tick();
        check("slt_opcod", {bus.opcod, bus.Cin}, {3'b111, 1'b1});

        // Reset mid-operation
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", bus.in_ready, 0);
        tick();
        check("rst_mid_state", {bus.out_valid, bus.opcod, bus.X}, {1'b0, 3'b010, 16'h0000});
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("rst_mid_after", bus.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
